// File: rtl/freq_measure.sv
// freq_measure -- reciprocal-free gated frequency counter with auto-ranging.
//
// Counts rising edges of sig_in over a fixed gate window of GATE_CYCLES clk
// cycles into a 4-digit saturating BCD counter. If the count saturates while
// the external prescaler is in pass-through, it switches the prescaler to
// divide-by-10; if the divided count drops below 0900 it switches back. Each
// range change is followed by a settle period so the prescaler output is
// stable before the next gate opens. Only windows that do not trigger a range
// change are published.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   sig_in     signal under test (asynchronous to clk)
//   mode_ctrl  prescaler range select (0 = pass-through, 1 = divide-by-10)
//   bcd_out    published count, 4 BCD digits (thousands in [15:12])
//   range_hi   published count is in units of 10 input edges
//   over       published count saturated at 9999 in the divided range
//   valid      one-cycle pulse marking a new publication

// One BCD digit of the edge counter; wraps 9 -> 0, carry is formed outside.
module bcdDigit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   digit <= 4'd0;
    else if (clr) digit <= 4'd0;
    else if (inc) digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
  end
endmodule

module freq_measure #(
  parameter int unsigned GATE_CYCLES   = 1000000,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_in,
  output logic        mode_ctrl,
  output logic [15:0] bcd_out,
  output logic        range_hi,
  output logic        over,
  output logic        valid
);
  localparam int NUM_DIGITS = 4;
  localparam int GATE_W     = $clog2(GATE_CYCLES);
  localparam int SETTLE_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [GATE_W-1:0]   GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {SETTLE, GATE, EVAL} stateT;

  stateT state, nextState;

  logic                             syncA, syncB, hist;
  logic                             edgeDet;
  logic [GATE_W-1:0]                gateCnt;
  logic [SETTLE_W-1:0]              settleCnt;
  logic [NUM_DIGITS-1:0][3:0]       digits;
  logic [NUM_DIGITS-1:0]            carry, isNine;
  logic                             allNines;
  logic                             ovf;
  logic                             countClr, countInc, setOvf, publish, modeNext;

  // Two-flop synchronizer plus a history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncA <= 1'b0;
      syncB <= 1'b0;
      hist  <= 1'b0;
    end else begin
      syncA <= sig_in;
      syncB <= syncA;
      hist  <= syncB;
    end
  end
  assign edgeDet = syncB & ~hist;

  // Ripple-carry BCD counter: digit i increments when all lower digits are 9.
  assign carry[0] = countInc;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : gDigit
    bcdDigit uDigit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (countClr),
      .inc   (carry[i]),
      .digit (digits[i])
    );
    assign isNine[i] = (digits[i] == 4'd9);
    if (i > 0) begin : gCarry
      assign carry[i] = carry[i-1] & isNine[i-1];
    end
  end
  assign allNines = &isNine;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SETTLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    countClr  = 1'b0;
    countInc  = 1'b0;
    setOvf    = 1'b0;
    publish   = 1'b0;
    modeNext  = mode_ctrl;
    case (state)
      SETTLE: begin
        countClr = 1'b1;
        if (settleCnt == SETTLE_LAST) nextState = GATE;
      end
      GATE: begin
        // At 9999 the edge is absorbed into the sticky overflow flag.
        if (edgeDet) begin
          if (allNines) setOvf   = 1'b1;
          else          countInc = 1'b1;
        end
        if (gateCnt == GATE_LAST) nextState = EVAL;
      end
      EVAL: begin
        countClr = 1'b1;
        if (!mode_ctrl && ovf) begin
          modeNext  = 1'b1;
          nextState = SETTLE;
        end else if (mode_ctrl && !ovf && digits[3] == 4'd0 && digits[2] < 4'd9) begin
          modeNext  = 1'b0;
          nextState = SETTLE;
        end else begin
          publish   = 1'b1;
          nextState = GATE;
        end
      end
      default: nextState = SETTLE;
    endcase
  end

  // Timers run only in their own state and sit at 0 everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settleCnt <= '0;
      gateCnt   <= '0;
      ovf       <= 1'b0;
    end else begin
      if (state == SETTLE) settleCnt <= (settleCnt == SETTLE_LAST) ? '0 : settleCnt + 1'b1;
      else                 settleCnt <= '0;
      if (state == GATE)   gateCnt <= (gateCnt == GATE_LAST) ? '0 : gateCnt + 1'b1;
      else                 gateCnt <= '0;
      if (countClr)        ovf <= 1'b0;
      else if (setOvf)     ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_ctrl <= 1'b0;
      bcd_out   <= 16'h0000;
      range_hi  <= 1'b0;
      over      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      mode_ctrl <= modeNext;
      valid     <= publish;
      if (publish) begin
        bcd_out  <= digits;
        range_hi <= mode_ctrl;
        over     <= ovf;
      end
    end
  end
endmodule

// File: tb/tb_freq_measure.sv
// Directed bench for freq_measure. Instance A (gate 1000) carries the
// timing, constant-input and reset scenarios; B/C (gates 1998/2000) check
// the BCD carry boundary; D (gate 20000, smallest round gate that saturates
// the count at period 2) runs the auto-range sequence in the background
// against a prescaler model and is checked last.
module tb_freq_measure;
  logic clk;
  logic rstA, rstG;
  logic sigA, sigBC, sigD;
  logic modeA, hiA, overA, validA; logic [15:0] bcdA;
  logic modeB, hiB, overB, validB; logic [15:0] bcdB;
  logic modeC, hiC, overC, validC; logic [15:0] bcdC;
  logic modeD, hiD, overD, validD; logic [15:0] bcdD;

  int checks = 0, failures = 0;

  freq_measure #(.GATE_CYCLES(1000), .SETTLE_CYCLES(4)) uA (
    .clk(clk), .rst_n(rstA), .sig_in(sigA), .mode_ctrl(modeA),
    .bcd_out(bcdA), .range_hi(hiA), .over(overA), .valid(validA));
  freq_measure #(.GATE_CYCLES(1998), .SETTLE_CYCLES(4)) uB (
    .clk(clk), .rst_n(rstG), .sig_in(sigBC), .mode_ctrl(modeB),
    .bcd_out(bcdB), .range_hi(hiB), .over(overB), .valid(validB));
  freq_measure #(.GATE_CYCLES(2000), .SETTLE_CYCLES(4)) uC (
    .clk(clk), .rst_n(rstG), .sig_in(sigBC), .mode_ctrl(modeC),
    .bcd_out(bcdC), .range_hi(hiC), .over(overC), .valid(validC));
  freq_measure #(.GATE_CYCLES(20000), .SETTLE_CYCLES(4)) uD (
    .clk(clk), .rst_n(rstG), .sig_in(sigD), .mode_ctrl(modeD),
    .bcd_out(bcdD), .range_hi(hiD), .over(overD), .valid(validD));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus for A: periodA = 0 means hold constA.
  int   periodA = 20;
  int   phA = 0;
  logic constA = 1'b0;
  initial begin
    sigA = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (periodA == 0) sigA = constA;
      else begin
        phA  = (phA >= periodA - 1) ? 0 : phA + 1;
        sigA = (phA < periodA / 2);
      end
    end
  end

  // Period-2 source shared by B and C.
  initial begin
    sigBC = 1'b0;
    forever begin
      @(posedge clk); #1;
      sigBC = ~sigBC;
    end
  end

  // Prescaler model for D: raw period rawP, divided by 10 when mode_ctrl = 1.
  // Once the divided range has published, the raw input slows to period 4.
  int rawP = 2;
  int phD = 0;
  int perD;
  initial begin
    sigD = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (validD && hiD) rawP = 4;
      perD = modeD ? 10 * rawP : rawP;
      phD  = (phD >= perD - 1) ? 0 : phD + 1;
      sigD = (phD < perD / 2);
    end
  end

  // Event log for D: publications and the valid count at each mode change.
  int          dValids = 0, dRiseAt = -1, dFallAt = -1;
  logic        dPrevMode = 1'b0;
  logic [15:0] dBcd  [0:1];
  logic        dHi   [0:1];
  logic        dOver [0:1];
  logic        dMode [0:1];
  initial begin
    forever begin
      @(negedge clk);
      if (validD) begin
        if (dValids < 2) begin
          dBcd[dValids] = bcdD; dHi[dValids] = hiD;
          dOver[dValids] = overD; dMode[dValids] = modeD;
        end
        dValids++;
      end
      if (modeD && !dPrevMode && dRiseAt < 0) dRiseAt = dValids;
      if (!modeD && dPrevMode && dFallAt < 0) dFallAt = dValids;
      dPrevMode = modeD;
    end
  end

  // Cycles until the next valid on A, sampled at negedge; -1 on timeout.
  task automatic waitValidA(output int n);
    n = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk); @(negedge clk);
      if (validA) begin n = i; return; end
    end
  endtask

  task automatic test_reset;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bcdA !== 16'h0000) begin failures++; $display("FAIL rst_bcd got=%h want=0000", bcdA); end
    checks++; if (modeA !== 1'b0) begin failures++; $display("FAIL rst_mode got=%b want=0", modeA); end
    checks++; if (hiA !== 1'b0) begin failures++; $display("FAIL rst_range_hi got=%b want=0", hiA); end
    checks++; if (overA !== 1'b0) begin failures++; $display("FAIL rst_over got=%b want=0", overA); end
    checks++; if (validA !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", validA); end
    @(posedge clk); #1;
    rstA = 1'b1; rstG = 1'b1;
    waitValidA(n);
    checks++; if (n !== 1005) begin failures++; $display("FAIL first_valid_latency got=%0d want=1005", n); end
    checks++; if (bcdA !== 16'h0050) begin failures++; $display("FAIL p20_bcd got=%h want=0050", bcdA); end
    checks++; if ({hiA, overA, modeA} !== 3'b000) begin failures++; $display("FAIL p20_flags got=%b want=000", {hiA, overA, modeA}); end
  endtask

  task automatic test_steady;
    int n;
    waitValidA(n);
    checks++; if (n !== 1001) begin failures++; $display("FAIL valid_spacing got=%0d want=1001", n); end
    checks++; if (bcdA !== 16'h0050) begin failures++; $display("FAIL steady_bcd got=%h want=0050", bcdA); end
    @(posedge clk); @(negedge clk);
    checks++; if (validA !== 1'b0) begin failures++; $display("FAIL valid_width got=%b want=0", validA); end
    repeat (400) @(negedge clk);
    checks++; if (bcdA !== 16'h0050) begin failures++; $display("FAIL bcd_hold got=%h want=0050", bcdA); end
  endtask

  task automatic test_const(input logic level);
    int n;
    periodA = 0; constA = level;
    waitValidA(n);
    waitValidA(n);
    checks++; if (n < 0) begin failures++; $display("FAIL const%0b_timeout got=%0d want=1001", level, n); end
    checks++; if (bcdA !== 16'h0000) begin failures++; $display("FAIL const%0b_bcd got=%h want=0000", level, bcdA); end
    checks++; if ({hiA, modeA} !== 2'b00) begin failures++; $display("FAIL const%0b_flags got=%b want=00", level, {hiA, modeA}); end
  endtask

  task automatic test_reset_mid;
    int n;
    periodA = 20;
    waitValidA(n);
    waitValidA(n);
    checks++; if (bcdA !== 16'h0050) begin failures++; $display("FAIL pre_reset_bcd got=%h want=0050", bcdA); end
    // Valid coincides with gate-timer 0, so 500 edges later the timer is 500.
    repeat (500) @(posedge clk);
    #1 rstA = 1'b0;
    #1;
    checks++; if ({bcdA, hiA, overA, validA, modeA} !== 20'h0) begin
      failures++; $display("FAIL async_reset got=%h/%b%b%b%b want=0000/0000", bcdA, hiA, overA, validA, modeA);
    end
    repeat (5) @(negedge clk);
    checks++; if ({bcdA, validA} !== 17'h0) begin failures++; $display("FAIL reset_hold got=%h/%b want=0000/0", bcdA, validA); end
    @(posedge clk); #1 rstA = 1'b1;
    waitValidA(n);
    checks++; if (n !== 1005) begin failures++; $display("FAIL post_reset_latency got=%0d want=1005", n); end
    checks++; if (bcdA !== 16'h0050) begin failures++; $display("FAIL post_reset_bcd got=%h want=0050", bcdA); end
  endtask

  task automatic test_bcd_carry;
    int n;
    n = -1;
    for (int i = 1; i <= 3000 && n < 0; i++) begin @(negedge clk); if (validB) n = i; end
    checks++; if (n < 0) begin failures++; $display("FAIL g1998_timeout got=%0d want>0", n); end
    checks++; if (bcdB !== 16'h0999) begin failures++; $display("FAIL g1998_bcd got=%h want=0999", bcdB); end
    checks++; if ({hiB, overB, modeB} !== 3'b000) begin failures++; $display("FAIL g1998_flags got=%b want=000", {hiB, overB, modeB}); end
    n = -1;
    for (int i = 1; i <= 3000 && n < 0; i++) begin @(negedge clk); if (validC) n = i; end
    checks++; if (n < 0) begin failures++; $display("FAIL g2000_timeout got=%0d want>0", n); end
    checks++; if (bcdC !== 16'h1000) begin failures++; $display("FAIL g2000_bcd got=%h want=1000", bcdC); end
    checks++; if ({hiC, overC, modeC} !== 3'b000) begin failures++; $display("FAIL g2000_flags got=%b want=000", {hiC, overC, modeC}); end
  endtask

  task automatic test_range;
    for (int i = 0; i < 90000 && dValids < 2; i++) @(negedge clk);
    checks++; if (dValids < 2) begin failures++; $display("FAIL range_timeout got=%0d want=2", dValids); end
    else begin
      checks++; if (dRiseAt !== 0) begin failures++; $display("FAIL up_range got=%0d want=0", dRiseAt); end
      checks++; if (dBcd[0] !== 16'h1000) begin failures++; $display("FAIL hi_bcd got=%h want=1000", dBcd[0]); end
      checks++; if ({dHi[0], dOver[0], dMode[0]} !== 3'b101) begin failures++; $display("FAIL hi_flags got=%b want=101", {dHi[0], dOver[0], dMode[0]}); end
      checks++; if (dFallAt !== 1) begin failures++; $display("FAIL down_range got=%0d want=1", dFallAt); end
      checks++; if (dBcd[1] !== 16'h5000) begin failures++; $display("FAIL lo_bcd got=%h want=5000", dBcd[1]); end
      checks++; if ({dHi[1], dOver[1], dMode[1]} !== 3'b000) begin failures++; $display("FAIL lo_flags got=%b want=000", {dHi[1], dOver[1], dMode[1]}); end
    end
  endtask

  initial begin
    rstA = 1'b1; rstG = 1'b1;
    #2 rstA = 1'b0; rstG = 1'b0;
    test_reset;
    test_steady;
    test_const(1'b0);
    test_const(1'b1);
    test_reset_mid;
    test_bcd_carry;
    test_range;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/freq_measure.md
FREQ_MEASURE -- requirements
Module: freq_measure

Interface
REQ-001 The module SHALL take parameter GATE_CYCLES, default 1000000, which sets the gate window length in clk cycles (minimum 16).
REQ-002 The module SHALL take parameter SETTLE_CYCLES, default 16, which sets the wait in clk cycles after a range change before the gate opens (minimum 1).
REQ-003 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 sig_in  input  1  signal under test from the frequency-range prescaler, asynchronous to clk.
REQ-006 mode_ctrl  output  1  range select driven to the prescaler (0 = pass-through, 1 = divide-by-10).
REQ-007 bcd_out  output  16  published count as 4 BCD digits; thousands in [15:12], units in [3:0].
REQ-008 range_hi  output  1  1 = bcd_out counts in units of 10 input edges.
REQ-009 over  output  1  1 = published count saturated at 9999 in divided range.
REQ-010 valid  output  1  one-cycle pulse marking a new published result.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected when synchronizer stage 2 = 1 and a third (history) flop = 0.
REQ-012 A detected edge SHALL be counted only in a cycle where the FSM is in GATE; edges detected in SETTLE or EVAL SHALL be discarded.
REQ-013 The counter SHALL be 4-digit BCD with digit carry (each digit 0-9; e.g. 0999 -> 1000).
REQ-014 An increment at 9999 SHALL leave the count at 9999 and set a sticky overflow flag for the current window.
REQ-015 The FSM SHALL have exactly three states: SETTLE, GATE and EVAL.
REQ-016 SETTLE SHALL hold the counter and overflow flag at 0 for SETTLE_CYCLES cycles, then enter GATE.
REQ-017 GATE SHALL last exactly GATE_CYCLES cycles, timed by a binary gate timer, then enter EVAL.
REQ-018 EVAL SHALL last one cycle, evaluate REQ-019..REQ-021 in priority order, and clear the counter, overflow flag and gate timer.
REQ-019 Up-range rule: if mode_ctrl = 0 and overflow = 1, mode_ctrl SHALL be set to 1, nothing is published, and the next state is SETTLE.
REQ-020 Down-range rule: if mode_ctrl = 1, overflow = 0 and count < 0900 (thousands digit = 0 and hundreds digit < 9), mode_ctrl SHALL be cleared to 0, nothing is published, and the next state is SETTLE.
REQ-021 Otherwise, on the clock edge leaving EVAL: bcd_out <= count, range_hi <= mode_ctrl, over <= overflow, and the next state is GATE.
REQ-022 valid SHALL be 1 for exactly the one cycle after a publishing EVAL, the same cycle the new bcd_out, range_hi and over first appear; valid SHALL be 0 at all other times.
REQ-023 bcd_out, range_hi and over SHALL hold their values between publications.
REQ-024 In steady state with no range change, valid SHALL recur every GATE_CYCLES+1 cycles.
REQ-025 mode_ctrl SHALL change only on leaving EVAL and never while in GATE.
REQ-026 sig_in high and low phases of at least 2 clk periods each SHALL be counted without loss.

Reset
REQ-027 While rst_n = 0, the module SHALL immediately drive mode_ctrl = 0, bcd_out = 16'h0000, range_hi = 0, over = 0 and valid = 0.
REQ-028 While rst_n = 0, the FSM SHALL be in SETTLE, and all counters, timers and synchronizer flops SHALL be 0.
REQ-029 A reset asserted mid-window SHALL discard the partial count and SHALL produce no valid pulse.
REQ-030 After reset release, the first valid SHALL occur SETTLE_CYCLES+GATE_CYCLES+1 cycles later, provided no range change occurs.

Verification
REQ-031 GATE_CYCLES=1000, SETTLE_CYCLES=4, sig_in period 20 clk -> each valid shows bcd_out=16'h0050, range_hi=0, over=0, mode_ctrl=0; valid spacing is 1001 cycles.
REQ-032 GATE_CYCLES=30000, sig_in period 2 clk with mode_ctrl=0; bench model switches to period 20 clk once mode_ctrl=1 -> no valid for the first window, mode_ctrl rises to 1, then valid shows bcd_out=16'h1500, range_hi=1, over=0.
REQ-033 Continuing from REQ-032, bench model switches to period 40 clk while mode_ctrl=1 (750 edges < 900) -> mode_ctrl returns to 0 with no valid that window; the next valid shows bcd_out=16'h7500, range_hi=0.
REQ-034 GATE_CYCLES=1998, sig_in period 2 clk -> bcd_out=16'h0999; with GATE_CYCLES=2000 -> bcd_out=16'h1000, confirming BCD carry.
REQ-035 sig_in held constant at 0, and separately held at 1 -> every valid shows bcd_out=16'h0000, range_hi=0, mode_ctrl=0.
REQ-036 rst_n pulsed low at gate-timer count 500 -> all outputs are 0 within the same cycle, no valid pulse for that window, and the first valid after release follows the timing of REQ-030.
